bram_result_reader: RTL

Drains multiplier results that the multiplier controller has written into the result region of the dual-port BRAM, and streams them to the user with a valid/ready handshake. It sits on the BRAM read port, on the opposite side from the controller's write port. It provides the read-back path for the product values the controller stores through port B.

---
 rtl/bram_mul_pkg.sv | 21 ++
 rtl/bram_rd_fifo2.sv | 51 +++++
 rtl/bram_result_reader.sv | 117 +++++++++++
 3 files changed

// File: rtl/bram_mul_pkg.sv
// Constants and types shared by the multiplier BRAM controller and result reader.
// The result-region placement must match the controller's write side.
package bram_mul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    DRAIN = 2'b10
  } state_t;

  localparam int              DEFAULT_DATA_WIDTH = 4;
  localparam logic [11:0]     DEFAULT_BASE_ADDR  = 12'h040;
  localparam int              DEFAULT_DEPTH      = 64;
  localparam int              DEFAULT_RES_WIDTH  = 2 * DEFAULT_DATA_WIDTH;

  // A product of two DATA_WIDTH operands occupies the low 2*DATA_WIDTH bits of a word.
  function automatic int res_width(input int data_width);
    return 2 * data_width;
  endfunction

endpackage

// File: rtl/bram_rd_fifo2.sv
// Two-entry synchronous FIFO that absorbs BRAM read data while the consumer stalls.
module bram_rd_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bram_result_reader.sv
// Streams multiplier results out of the BRAM result region over a valid/ready port.
// Reads are credit-limited so every returned word always has a FIFO slot waiting.
module bram_result_reader
  import bram_mul_pkg::*;
#(
  parameter int                   DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int                   BRAM_WIDTH = 18,
  parameter int                   BRAM_ADDR  = 12,
  parameter logic [BRAM_ADDR-1:0] BASE_ADDR  = BRAM_ADDR'(DEFAULT_BASE_ADDR),
  parameter int                   DEPTH      = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BRAM_ADDR-1:0]    len,
  output logic                    rd_en,
  output logic [BRAM_ADDR-1:0]    rd_addr,
  input  logic [BRAM_WIDTH-1:0]   rd_dout,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2*DATA_WIDTH-1:0] res_data,
  output logic                    res_last,
  output logic                    busy,
  output logic                    done,
  output logic                    fmt_err
);

  localparam int                   RW        = res_width(DATA_WIDTH);
  localparam logic [BRAM_ADDR-1:0] LAST_ADDR = BASE_ADDR + BRAM_ADDR'(DEPTH - 1);
  localparam logic [BRAM_ADDR-1:0] ONE       = BRAM_ADDR'(1);

  state_t               state;
  logic [BRAM_ADDR-1:0] issue_cnt;
  logic [BRAM_ADDR-1:0] beat_cnt;
  logic                 in_flight;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [1:0]           fifo_count;
  logic [2:0]           committed;

  // Slots already spoken for once this cycle's pop leaves: a read issued now
  // lands two edges later, so it needs one slot free after the pop.
  assign pop       = res_valid && res_ready;
  assign committed = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};
  assign rd_en     = (state == READ) && (issue_cnt != '0) && !fifo_full && (committed < 3'd2);
  assign res_valid = !fifo_empty;
  assign res_last  = res_valid && (beat_cnt == ONE);
  assign busy      = (state != IDLE);

  bram_rd_fifo2 #(
    .WIDTH (RW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_flight),
    .pop   (pop),
    .din   (rd_dout[RW-1:0]),
    .dout  (res_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      rd_addr   <= BASE_ADDR;
      in_flight <= 1'b0;
      done      <= 1'b0;
      fmt_err   <= 1'b0;
    end else begin
      done      <= 1'b0;
      in_flight <= rd_en;
      if (in_flight && (|rd_dout[BRAM_WIDTH-1:RW])) begin
        fmt_err <= 1'b1;
      end
      if (pop) begin
        beat_cnt <= beat_cnt - ONE;
      end
      case (state)
        IDLE: begin
          if (start) begin
            fmt_err <= 1'b0;
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              issue_cnt <= len;
              beat_cnt  <= len;
              rd_addr   <= BASE_ADDR;
              state     <= READ;
            end
          end
        end
        READ: begin
          if (rd_en) begin
            issue_cnt <= issue_cnt - ONE;
            rd_addr   <= (rd_addr == LAST_ADDR) ? BASE_ADDR : rd_addr + ONE;
            if (issue_cnt == ONE) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && (beat_cnt == ONE)) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
